// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces a push-button, emitting a clean level plus press/release pulses.
// Optional long-press pulse under BUTTON_DEBOUNCE_LONG_PRESS_EN; release pulse port is release_pulse (release is a reserved word).
module button_debounce #(
  parameter int DEBOUNCE_WIDTH = 14,
  parameter int LONG_WIDTH     = 20,
  parameter bit ACTIVE_LOW     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic button_clean,
  output logic press,
  output logic release_pulse,
  output logic long_press
);
  typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} state_t;
  state_t state;
  logic s1, s2, p;
  logic [DEBOUNCE_WIDTH-1:0] cnt;
  assign p = s2 ^ ACTIVE_LOW;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
      state <= UP;
      cnt <= '0;
      button_clean <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= button_raw;
      s2 <= s1;
      press <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        UP: if (p) begin
          state <= WAIT_DN;
          cnt <= '0;
        end
        WAIT_DN: if (!p) begin
          state <= UP;
          cnt <= '0;
        end else if (cnt != '1) cnt <= cnt + 1'b1;
        else begin
          state <= DOWN;
          press <= 1'b1;
          button_clean <= 1'b1;
        end
        DOWN: if (!p) begin
          state <= WAIT_UP;
          cnt <= '0;
        end
        default: if (p) begin
          state <= DOWN;
          cnt <= '0;
        end else if (cnt != '1) cnt <= cnt + 1'b1;
        else begin
          state <= UP;
          release_pulse <= 1'b1;
          button_clean <= 1'b0;
        end
      endcase
    end
  end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  logic [LONG_WIDTH-1:0] lcnt;
  logic long_done, new_press, enter_down;
  always_comb begin
    new_press = state == WAIT_DN && p && cnt == '1;
    enter_down = new_press || (state == WAIT_UP && p);
  end
  // long_done survives bounces back into DOWN so a single hold fires only once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcnt <= '0;
      long_done <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (enter_down) lcnt <= '0;
      if (new_press) long_done <= 1'b0;
      if (state == DOWN) begin
        if (lcnt != '1) lcnt <= lcnt + 1'b1;
        else if (!long_done) begin
          long_press <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed stimulus with a pulse scoreboard for button_debounce (3-bit debounce, 5-bit long counter).
module tb_button_debounce;
  logic clk = 1'b0, rst_n = 1'b0, button_raw = 1'b1;
  logic button_clean, press, release_pulse, long_press;
  int e = 0, checks = 0, errors = 0;
  typedef struct {int kind; int cyc;} ev_t;
  ev_t q[$];

  button_debounce #(.DEBOUNCE_WIDTH(3), .LONG_WIDTH(5), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .button_raw(button_raw), .button_clean(button_clean),
    .press(press), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, e);
    end
  endtask

  task automatic take(int k);
    ev_t ev;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL pulse: unexpected kind %0d at edge %0d", k, e);
    end else begin
      ev = q.pop_front();
      if (ev.kind != k || ev.cyc != e) begin
        errors++;
        $display("FAIL pulse: got kind %0d at edge %0d expected kind %0d at edge %0d", k, e, ev.kind, ev.cyc);
      end
    end
  endtask

  // kinds: 0 press, 1 release, 2 long_press
  always @(negedge clk) begin
    if (press) take(0);
    if (release_pulse) take(1);
    if (long_press) take(2);
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(int k, int lat);
    ev_t ev;
    ev.kind = k;
    ev.cyc = e + 1 + lat;
    q.push_back(ev);
  endtask

  task automatic reset_check(string name);
    rst_n = 1'b0;
    repeat (3) begin
      wait_cyc(1);
      chk(name, {button_clean, press, release_pulse, long_press}, 4'b0000);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    wait_cyc(1);
    reset_check("reset");
    wait_cyc(5);
    // glitch from idle
    button_raw = 1'b0;
    wait_cyc(5);
    button_raw = 1'b1;
    wait_cyc(20);
    chk("glitch_clean", {3'b0, button_clean}, 4'b0000);
    // clean press held 40 cycles, then release
    button_raw = 1'b0;
    expect_ev(0, 10);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    expect_ev(2, 42);
`endif
    wait_cyc(15);
    chk("press_clean", {3'b0, button_clean}, 4'b0001);
    wait_cyc(25);
    button_raw = 1'b1;
    expect_ev(1, 10);
    wait_cyc(20);
    chk("release_clean", {3'b0, button_clean}, 4'b0000);
    // bounce every 3 cycles, then settle low
    for (int i = 0; i < 10; i++) begin
      button_raw = i[0];
      wait_cyc(3);
    end
    chk("bounce_clean", {3'b0, button_clean}, 4'b0000);
    button_raw = 1'b0;
    expect_ev(0, 10);
    wait_cyc(20);
    chk("bounce_press_clean", {3'b0, button_clean}, 4'b0001);
    button_raw = 1'b1;
    expect_ev(1, 10);
    wait_cyc(20);
    chk("bounce_release_clean", {3'b0, button_clean}, 4'b0000);
    // long hold
    button_raw = 1'b0;
    expect_ev(0, 10);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    expect_ev(2, 42);
`endif
    wait_cyc(60);
    chk("long_clean", {3'b0, button_clean}, 4'b0001);
    button_raw = 1'b1;
    expect_ev(1, 10);
    wait_cyc(20);
    chk("long_release_clean", {3'b0, button_clean}, 4'b0000);
    // reset while in WAIT_DN with the button held
    button_raw = 1'b0;
    wait_cyc(5);
    reset_check("mid_reset");
    expect_ev(0, 10);
    wait_cyc(20);
    chk("post_reset_clean", {3'b0, button_clean}, 4'b0001);
    button_raw = 1'b1;
    expect_ev(1, 10);
    wait_cyc(20);
    chk("final_clean", {3'b0, button_clean}, 4'b0000);
    chk("missing_pulses", 4'(q.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
